// File: rtl/usb_pkg.sv
// Shared definitions for the device-side USB transaction responder.
// Holds the wire-order PID constants, the responder state encoding and the
// token packet layout used by usb_dev_responder.
package usb_pkg;

  // PIDs as they appear on the wire (bit-reversed relative to the USB tables).
  localparam logic [7:0] PID_OUT   = 8'b10000111;
  localparam logic [7:0] PID_IN    = 8'b10010110;
  localparam logic [7:0] PID_DATA0 = 8'b11000011;
  localparam logic [7:0] PID_ACK   = 8'b01001011;
  localparam logic [7:0] PID_NAK   = 8'b01011010;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OUT_WAIT  = 3'd1,
    ST_WR_MEM    = 3'd2,
    ST_RD_MEM    = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_SEND_HS   = 3'd5,
    ST_SEND_DATA = 3'd6,
    ST_WAIT_ACK  = 3'd7
  } resp_state_e;

  typedef struct packed {
    logic [7:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
  } tok_t;

endpackage

// File: rtl/usb_dev_responder_reverser.sv
// Bit-order reverser: dout[i] = din[W-1-i]. Purely combinational.
// Ports: din  - input word
//        dout - same word with bit order reversed
module usb_dev_responder_reverser #(
  parameter int W = 64
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // Mirror the bit order of the whole word.
  always_comb begin
    dout = '0;
    for (int i = 0; i < W; i++) begin
      dout[i] = din[W-1-i];
    end
  end

endmodule

// File: rtl/usb_dev_responder.sv
// Device-side USB transaction responder.
// An OUT(ENDP_OUT)+DATA0 first loads a 16-bit page address; a second OUT+DATA0
// writes 64 bits to that page, while an IN(ENDP_IN) reads it back as DATA0.
// Responses are ACK/NAK handshakes or a DATA0 packet to the transmit path.
// Ports: clk/rst_b (sync active-low reset); tok_*/data_*/hs_*/rx_error from the
//   receive path; tx_ready, hs_send/hs_pkt_out, data_send/data_pkt_out to the
//   transmit path; mem_* to the synchronous page memory; busy = not idle.
// Optional feature: define RESP_TIMEOUT_EN to leave WAIT_ACK after TIMEOUT
//   cycles without a host handshake.
module usb_dev_responder
  import usb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'b1010000,
  parameter logic [3:0] ENDP_OUT = 4'b0010,
  parameter logic [3:0] ENDP_IN  = 4'b0001
`ifdef RESP_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        tok_valid,
  input  logic [18:0] tok_pkt,
  input  logic        data_valid,
  input  logic [71:0] data_pkt,
  input  logic        rx_error,
  input  logic        hs_valid,
  input  logic [7:0]  hs_pid,
  input  logic        tx_ready,
  output logic        hs_send,
  output logic [7:0]  hs_pkt_out,
  output logic        data_send,
  output logic [71:0] data_pkt_out,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  resp_state_e state_q, state_d;
  logic        addr_vld_q, addr_vld_d;
  logic        data_held_q, data_held_d;
  logic [63:0] held_q, held_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic        hs_send_q, hs_send_d;
  logic [7:0]  hs_pkt_q, hs_pkt_d;
  logic        data_send_q, data_send_d;
  logic [71:0] data_pkt_q, data_pkt_d;
  logic        busy_q, busy_d;
`ifdef RESP_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  timer_q, timer_d;
`endif

  tok_t        tok_s;
  logic        tok_acc_s, data_acc_s, hs_ack_s;
  logic [63:0] payload_s, out_src_s, out_rev_s;

  assign tok_s = tok_pkt;
  // A token sharing its cycle with a data packet is dropped.
  assign tok_acc_s  = tok_valid & ~data_valid & ~rx_error & (tok_s.addr == DEV_ADDR);
  assign data_acc_s = data_valid & ~rx_error & (data_pkt[71:64] == PID_DATA0);
  assign hs_ack_s   = hs_valid & ~rx_error & (hs_pid == PID_ACK);

  // In RD_WAIT the packet is built straight from the memory word being captured.
  assign out_src_s = (state_q == ST_RD_WAIT) ? mem_rdata : held_q;

  usb_dev_responder_reverser #(.W(64)) u_rx_rev (.din(data_pkt[63:0]), .dout(payload_s));
  usb_dev_responder_reverser #(.W(64)) u_tx_rev (.din(out_src_s),      .dout(out_rev_s));

  // Next-state and next-output decision for every state.
  always_comb begin
    state_d     = state_q;
    addr_vld_d  = addr_vld_q;
    data_held_d = data_held_q;
    held_d      = held_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    hs_send_d   = hs_send_q;
    hs_pkt_d    = hs_pkt_q;
    data_send_d = data_send_q;
    data_pkt_d  = data_pkt_q;
`ifdef RESP_TIMEOUT_EN
    timer_d     = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tok_acc_s) begin
          if ((tok_s.pid == PID_OUT) && (tok_s.endp == ENDP_OUT)) begin
            state_d = ST_OUT_WAIT;
          end else if ((tok_s.pid == PID_IN) && (tok_s.endp == ENDP_IN) && addr_vld_q) begin
            if (data_held_q) begin
              // Retried IN after a lost ACK: resend without touching memory.
              state_d     = ST_SEND_DATA;
              data_send_d = 1'b1;
              data_pkt_d  = {PID_DATA0, out_rev_s};
            end else begin
              state_d  = ST_RD_MEM;
              mem_re_d = 1'b1;
            end
          end else begin
            state_d   = ST_SEND_HS;
            hs_send_d = 1'b1;
            hs_pkt_d  = PID_NAK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT_WAIT: begin
        if (data_valid) begin
          if (data_acc_s && addr_vld_q) begin
            mem_wdata_d = payload_s;
            mem_we_d    = 1'b1;
            state_d     = ST_WR_MEM;
          end else if (data_acc_s) begin
            mem_addr_d  = payload_s[15:0];
            addr_vld_d  = 1'b1;
            data_held_d = 1'b0;
            state_d     = ST_SEND_HS;
            hs_send_d   = 1'b1;
            hs_pkt_d    = PID_ACK;
          end else begin
            // Corrupt or wrong-PID data: stay silent so the host retries.
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_OUT_WAIT;
        end
      end
      ST_WR_MEM: begin
        addr_vld_d  = 1'b0;
        data_held_d = 1'b0;
        state_d     = ST_SEND_HS;
        hs_send_d   = 1'b1;
        hs_pkt_d    = PID_ACK;
      end
      ST_RD_MEM: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        held_d      = mem_rdata;
        data_held_d = 1'b1;
        data_send_d = 1'b1;
        data_pkt_d  = {PID_DATA0, out_rev_s};
        state_d     = ST_SEND_DATA;
      end
      ST_SEND_HS: begin
        if (tx_ready) begin
          hs_send_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          hs_send_d = 1'b1;
        end
      end
      ST_SEND_DATA: begin
        if (tx_ready) begin
          data_send_d = 1'b0;
          state_d     = ST_WAIT_ACK;
`ifdef RESP_TIMEOUT_EN
          timer_d     = 8'd0;
`endif
        end else begin
          data_send_d = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (hs_valid) begin
          if (hs_ack_s) begin
            addr_vld_d  = 1'b0;
            data_held_d = 1'b0;
          end else begin
            addr_vld_d  = addr_vld_q;
          end
          state_d = ST_IDLE;
        end else begin
`ifdef RESP_TIMEOUT_EN
          if (timer_q == TIMEOUT_LAST) begin
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q + 8'd1;
          end
`else
          state_d = ST_WAIT_ACK;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      addr_vld_q  <= 1'b0;
      data_held_q <= 1'b0;
      held_q      <= 64'd0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 64'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      hs_send_q   <= 1'b0;
      hs_pkt_q    <= 8'd0;
      data_send_q <= 1'b0;
      data_pkt_q  <= 72'd0;
      busy_q      <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      timer_q     <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_vld_q  <= addr_vld_d;
      data_held_q <= data_held_d;
      held_q      <= held_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      hs_send_q   <= hs_send_d;
      hs_pkt_q    <= hs_pkt_d;
      data_send_q <= data_send_d;
      data_pkt_q  <= data_pkt_d;
      busy_q      <= busy_d;
`ifdef RESP_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign hs_send      = hs_send_q;
  assign hs_pkt_out   = hs_pkt_q;
  assign data_send    = data_send_q;
  assign data_pkt_out = data_pkt_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign mem_re       = mem_re_q;
  assign busy         = busy_q;

endmodule
